// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: FSM state encodings and code-range helper.
package scan_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Highest code reachable on an addr bus of the given width.
   function automatic int addr_max(input int addr_w);
      return (1 << addr_w) - 1;
   endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable dwell counter: counts up to limit, then holds and flags expire.
// Latency: expire is a compare on the registered count (same cycle as count).
// Backpressure: none; en gates counting, clr has priority over en.
module scan_dwell_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [DWELL_W-1:0] limit,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt < limit)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (cnt == limit);

endmodule

// File: rtl/scan_sequencer.sv
// Steps addr through every code with a programmable dwell; single-pass or looping, up or down.
// Latency: start sampled at edge N puts the first code on addr after edge N; all outputs registered.
// Backpressure: none; stop aborts a run next cycle and overrides end-of-pass handling.
module scan_sequencer
   import scan_sequencer_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_loop,
   input  logic               dir_down,
   input  logic [DWELL_W-1:0] dwell,
   output logic [ADDR_W-1:0]  addr,
   output logic               addr_valid,
   output logic               step,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(addr_max(ADDR_W));

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               step_nxt;
   logic               done_nxt;
   logic               latch;
   logic               tmr_clr;
   logic               tmr_en;
   logic               expire;
   logic               terminal;
   logic [DWELL_W-1:0] dwell_q;
   logic               dir_q;
   logic               loop_q;

   scan_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .limit  (dwell_q),
      .expire (expire)
   );

   assign terminal = dir_q ? (addr == '0) : (addr == ADDR_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      step_nxt  = 1'b0;
      done_nxt  = 1'b0;
      latch     = 1'b0;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               state_nxt = ST_RUN;
               addr_nxt  = dir_down ? ADDR_MAX : '0;
               step_nxt  = 1'b1;
               latch     = 1'b1;
               tmr_clr   = 1'b1;
            end
         end
         ST_RUN: begin
            // stop wins over terminal handling so an aborted pass never reports done
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (!expire) begin
               tmr_en = 1'b1;
            end else if (!terminal) begin
               addr_nxt = dir_q ? (addr - 1'b1) : (addr + 1'b1);
               step_nxt = 1'b1;
               tmr_clr  = 1'b1;
            end else if (loop_q) begin
               addr_nxt = dir_q ? ADDR_MAX : '0;
               step_nxt = 1'b1;
               tmr_clr  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         step       <= 1'b0;
         done       <= 1'b0;
         dwell_q    <= '0;
         dir_q      <= 1'b0;
         loop_q     <= 1'b0;
      end else begin
         addr       <= addr_nxt;
         addr_valid <= (state_nxt == ST_RUN);
         busy       <= (state_nxt == ST_RUN);
         step       <= step_nxt;
         done       <= done_nxt;
         if (latch) begin
            dwell_q <= dwell;
            dir_q   <= dir_down;
            loop_q  <= mode_loop;
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized bench for scan_sequencer: a per-cycle expectation queue built from the
// pass arithmetic is drained by a monitor whenever addr_valid or done is presented.
module tb_scan_sequencer;

   localparam int ADDR_W  = 3;
   localparam int DWELL_W = 8;
   localparam int NCODE   = 1 << ADDR_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic               mode_loop;
   logic               dir_down;
   logic [DWELL_W-1:0] dwell;
   logic [ADDR_W-1:0]  addr;
   logic               addr_valid;
   logic               step;
   logic               busy;
   logic               done;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              step;
   } rec_t;

   rec_t              exp_q[$];
   logic [ADDR_W-1:0] done_q[$];
   int                errors = 0;
   int                checks = 0;

   scan_sequencer #(
      .ADDR_W  (ADDR_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .mode_loop  (mode_loop),
      .dir_down   (dir_down),
      .dwell      (dwell),
      .addr       (addr),
      .addr_valid (addr_valid),
      .step       (step),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Code shown in cycle j of a run: each code lasts d+1 cycles, passes wrap every NCODE codes.
   function automatic logic [ADDR_W-1:0] code_at(input int j, input bit dn, input int d);
      int idx;
      idx = (j / (d + 1)) % NCODE;
      return dn ? ADDR_W'(NCODE - 1 - idx) : ADDR_W'(idx);
   endfunction

   always @(negedge clk) begin
      rec_t r;
      check("busy_vs_valid", {31'd0, busy}, {31'd0, addr_valid});
      if (addr_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: addr=%0d with no expected cycle at %0t", addr, $time);
         end else begin
            r = exp_q.pop_front();
            check("addr", {29'd0, addr}, {29'd0, r.addr});
            check("step", {31'd0, step}, {31'd0, r.step});
         end
      end else begin
         check("idle_step", {31'd0, step}, 32'd0);
      end
      if (done) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: addr=%0d at %0t", addr, $time);
         end else begin
            check("done_addr", {29'd0, addr}, {29'd0, done_q.pop_front()});
         end
      end
   end

   // cut>0 ends the run at run-cycle cut via stop (or rst when use_rst) unless the pass finished first.
   task automatic run(input bit dn, input bit lp, input int d, input int cut, input bit use_rst);
      int total;
      bit cutting;
      int limit;
      total   = NCODE * (d + 1);
      cutting = lp || (cut != 0 && cut <= total);
      limit   = cutting ? cut : total;
      for (int j = 0; j < limit; j++) begin
         exp_q.push_back('{addr: code_at(j, dn, d), step: (j % (d + 1)) == 0});
      end
      if (!cutting) done_q.push_back(dn ? ADDR_W'(0) : ADDR_W'(NCODE - 1));

      @(negedge clk);
      start     = 1'b1;
      stop      = 1'b0;
      mode_loop = lp;
      dir_down  = dn;
      dwell     = DWELL_W'(d);
      @(negedge clk);
      for (int k = 1; k < limit; k++) begin
         start     = ($urandom_range(0, 3) == 0);
         dwell     = DWELL_W'($urandom);
         dir_down  = 1'($urandom);
         mode_loop = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      if (cutting) begin
         if (use_rst) rst = 1'b1;
         else stop = 1'b1;
         @(negedge clk);
         rst  = 1'b0;
         stop = 1'b0;
         check("cut_valid", {31'd0, addr_valid}, 32'd0);
         check("cut_addr", {29'd0, addr},
               use_rst ? 32'd0 : {29'd0, code_at(limit - 1, dn, d)});
      end else begin
         @(negedge clk);
         check("pass_done", {31'd0, done}, 32'd1);
         check("pass_addr", {29'd0, addr}, dn ? 32'd0 : NCODE - 1);
         check("pass_busy", {31'd0, busy}, 32'd0);
      end
      repeat (3) @(negedge clk);
      check("idle_done", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      mode_loop = 1'b0;
      dir_down  = 1'b0;
      dwell     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_addr", {29'd0, addr}, 32'd0);
      check("rst_valid", {31'd0, addr_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_step", {31'd0, step}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      run(1'b1, 1'b0, 19, 0, 1'b0);   // down single pass, 20 cycles per code
      run(1'b0, 1'b0, 0, 0, 1'b0);    // up single pass, one cycle per code
      run(1'b1, 1'b1, 1, 40, 1'b0);   // looping down, stopped after 2.5 passes
      run(1'b1, 1'b0, 3, 14, 1'b0);   // stop while addr=4
      run(1'b0, 1'b0, 2, 7, 1'b1);    // rst while addr=2
      run(1'b0, 1'b0, 3, 0, 1'b0);    // in-run dwell changes must not alter the hold

      @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_idle", {31'd0, addr_valid}, 32'd0);
      repeat (2) @(negedge clk);
      check("start_stop_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 25; i++) begin
         bit dn;
         bit lp;
         int d;
         int total;
         int cut;
         dn    = 1'($urandom);
         lp    = ($urandom_range(0, 3) == 0);
         d     = $urandom_range(0, 5);
         total = NCODE * (d + 1);
         if (lp) cut = $urandom_range(1, 3 * total);
         else if ($urandom_range(0, 1) == 0) cut = 0;
         else cut = $urandom_range(1, total + 3);
         run(dn, lp, d, cut, $urandom_range(0, 4) == 0);
      end

      repeat (2) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("done_q_empty", done_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
